seq_divider: RTL
================

Name: seq_divider

Overview:
- Parametrised sequential radix-2 non-restoring integer divider: start/busy/done handshake, unsigned and signed (truncating) modes.
- Flags divide-by-zero and signed overflow explicitly.
- Next-generation divide unit alongside the shared adder/FSM datapath blocks.
- One quotient bit per clock, fixed latency, then a single correction/sign-fix cycle.

Parameters:
- WIDTH, 32, operand/result width in bits (legal: 4..64).
- SIGNED_EN, 1, 1 = signed_mode honoured; 0 = signed_mode ignored, always unsigned.

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- signed_mode  input  1  1 = two's-complement operands; sampled with start
- dividend  input  WIDTH  sampled with start
- divisor  input  WIDTH  sampled with start
- busy  output  1  high while iterating/correcting
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder
- div_by_zero  output  1  divisor was 0 (valid with done, held)
- overflow  output  1  signed MIN/-1 (valid with done, held)

Behaviour:
- Reset: async on rst_b low → state IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0; iteration counter 0.
- Reset mid-operation aborts the division: no done pulse and no output update.
- Operand capture: start=1 at edge k with busy=0 (state IDLE or DONE) latches dividend, divisor and effective mode.
  - sm = signed_mode & SIGNED_EN.
  - start while busy=1 is ignored; operand changes after capture have no effect.
- Short-circuit cases (decided at edge k, go directly to DONE; done high in the cycle after edge k+1):
  - divisor == 0: quotient = all ones, remainder = dividend, div_by_zero = 1.
  - sm & dividend == MIN & divisor == all ones: quotient = MIN, remainder = 0, overflow = 1.
- Normal path states:
  - IDLE → ITER on accepted start.
  - ITER runs WIDTH cycles; counter 0..WIDTH-1 of width $clog2(WIDTH)+1. Leave after the cycle with counter == WIDTH-1.
  - FIX: 1 cycle.
  - DONE: 1 cycle, done = 1, then back to IDLE (or to ITER if a new start is accepted).
- Normal-path timing: done is high in the cycle following edge k+WIDTH+2; busy is high for exactly WIDTH+1 cycles (ITER + FIX).
- Iteration:
  - Operate on magnitudes |dividend| and |divisor| (WIDTH-bit unsigned).
  - Partial remainder A is WIDTH+1 bits signed.
  - Each cycle: shift {A,Q} left by 1. If A ≥ 0, A = A − M, else A = A + M. Then Q[0] = ~A[WIDTH].
- FIX:
  - If A < 0, A = A + M.
  - If sm and the operand signs differ, negate the quotient.
  - If sm and the dividend is negative, negate the remainder (remainder sign follows dividend).
  - Results are registered into the output regs at the FIX→DONE edge.
- Outputs hold their last values until the next done; flags clear when the next start is accepted.
- Magnitude of MIN: |MIN| as WIDTH-bit unsigned = 2^(WIDTH-1), which is correct without extension.
- Back-to-back: start in the DONE cycle is accepted, so there is no dead cycle between operations.

Test Plan:
- WIDTH=32, unsigned, 4802 / 172 → done 34 cycles after start; quotient 27, remainder 158, both flags 0.
- WIDTH=32, signed, −4802 / 172 → quotient −27 (0xFFFFFFE5), remainder −158 (0xFFFFFF62); 4802 / −172 → quotient −27, remainder 158.
- Divide by zero: 100 / 0 (either mode) → done in the cycle after edge k+1; quotient 0xFFFFFFFF, remainder 100, div_by_zero 1.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, overflow 1.
- Same operands unsigned → quotient 0, remainder 0x80000000, no flags.
- Handshake: start pulsed mid-operation is ignored (exactly one done); start in the DONE cycle begins the next op with no gap; rst_b low at cycle 10 of an op → busy 0, no done, outputs 0.
- WIDTH=8, SIGNED_EN=0, signed_mode=1, 200 / 7 → unsigned result quotient 28, remainder 4; done 10 cycles after start.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential radix-2 non-restoring integer divider: one quotient bit per clock
// followed by a single correction/sign-fix cycle, with divide-by-zero and signed
// overflow short-circuited straight to completion.
module seq_divider #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   ZERO_A   = {(WIDTH+1){1'b0}};
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             sc_dbz_r;
  logic             sc_ovf_r;

  logic             sm_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic [WIDTH-1:0] mag_dvd_s;
  logic [WIDTH-1:0] mag_dvs_s;
  logic             dbz_s;
  logic             ovf_s;
  logic [WIDTH:0]   m_ext_s;
  logic [WIDTH:0]   a_sh_s;
  logic [WIDTH:0]   a_step_s;
  logic [WIDTH-1:0] q_step_s;
  logic [WIDTH:0]   a_fix_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  // Operand classification and magnitudes at the start handshake
  always_comb begin
    sm_s      = signed_mode & SIGNED_EN;
    dvd_neg_s = sm_s & dividend[WIDTH-1];
    dvs_neg_s = sm_s & divisor[WIDTH-1];
    if (dvd_neg_s) begin
      mag_dvd_s = (~dividend) + ONE_W;
    end else begin
      mag_dvd_s = dividend;
    end
    if (dvs_neg_s) begin
      mag_dvs_s = (~divisor) + ONE_W;
    end else begin
      mag_dvs_s = divisor;
    end
    dbz_s = (divisor == ZERO_W);
    ovf_s = sm_s & (dividend == MIN_W) & (divisor == ONES_W);
  end

  // One non-restoring step plus the final correction/sign fix
  always_comb begin
    m_ext_s = {1'b0, m_r};
    a_sh_s  = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
    // A is allowed to wrap after the shift; the add/sub brings it back into range
    if (a_r[WIDTH]) begin
      a_step_s = a_sh_s + m_ext_s;
    end else begin
      a_step_s = a_sh_s - m_ext_s;
    end
    q_step_s = {q_r[WIDTH-2:0], ~a_step_s[WIDTH]};
    if (a_r[WIDTH]) begin
      a_fix_s = a_r + m_ext_s;
    end else begin
      a_fix_s = a_r;
    end
    if (neg_q_r) begin
      quo_fix_s = (~q_r) + ONE_W;
    end else begin
      quo_fix_s = q_r;
    end
    if (neg_r_r) begin
      rem_fix_s = (~a_fix_s[WIDTH-1:0]) + ONE_W;
    end else begin
      rem_fix_s = a_fix_s[WIDTH-1:0];
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      a_r         <= ZERO_A;
      q_r         <= ZERO_W;
      m_r         <= ZERO_W;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      sc_dbz_r    <= 1'b0;
      sc_ovf_r    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= ZERO_W;
      remainder   <= ZERO_W;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= (state_r == DONE);
      case (state_r)
        IDLE, DONE: begin
          // Short-circuit results are published as DONE is left, in step with done
          if (state_r == DONE) begin
            if (sc_dbz_r || sc_ovf_r) begin
              quotient    <= q_r;
              remainder   <= a_r[WIDTH-1:0];
              div_by_zero <= sc_dbz_r;
              overflow    <= sc_ovf_r;
            end
            sc_dbz_r <= 1'b0;
            sc_ovf_r <= 1'b0;
          end
          if (start) begin
            if (state_r == IDLE) begin
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
            cnt_r    <= CNT_ZERO;
            neg_q_r  <= dvd_neg_s ^ dvs_neg_s;
            neg_r_r  <= dvd_neg_s;
            sc_dbz_r <= dbz_s;
            sc_ovf_r <= ovf_s & ~dbz_s;
            if (dbz_s) begin
              q_r     <= ONES_W;
              a_r     <= {1'b0, dividend};
              state_r <= DONE;
            end else if (ovf_s) begin
              q_r     <= MIN_W;
              a_r     <= ZERO_A;
              state_r <= DONE;
            end else begin
              q_r     <= mag_dvd_s;
              a_r     <= ZERO_A;
              m_r     <= mag_dvs_s;
              busy    <= 1'b1;
              state_r <= ITER;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ITER: begin
          a_r   <= a_step_s;
          q_r   <= q_step_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= FIX;
          end else begin
            state_r <= ITER;
          end
        end
        FIX: begin
          quotient    <= quo_fix_s;
          remainder   <= rem_fix_s;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          busy        <= 1'b0;
          state_r     <= DONE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
